sr_cmd_gen: RTL
===============

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the number of consecutive cycles a synchronized input must differ from its debounced value before that value changes (legal 2..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of each event counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 btn_set  input  1  SHALL be the raw, asynchronous, bouncing "set" request.
REQ-006 btn_rst  input  1  SHALL be the raw, asynchronous, bouncing "reset" request.
REQ-007 S  output  1  SHALL be the registered one-cycle set pulse driving the downstream SR flip-flop S input.
REQ-008 R  output  1  SHALL be the registered one-cycle reset pulse driving the downstream SR flip-flop R input.
REQ-009 conflict  output  1  SHALL be a registered one-cycle pulse flagging simultaneous set and reset presses.
REQ-010 set_cnt  output  CNT_W  SHALL count issued S pulses.
REQ-011 rst_cnt  output  CNT_W  SHALL count issued R pulses.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (stages s1, s2).
REQ-013 Each channel SHALL hold a debounced value "stable" and a counter "dcnt" of at least 8 bits.
REQ-014 dcnt SHALL clear to 0 on any edge where s2 equals stable.
REQ-015 dcnt SHALL increment on an edge where s2 differs from stable and dcnt is below DEB_CYCLES-1.
REQ-016 On an edge where s2 differs from stable and dcnt equals DEB_CYCLES-1, stable SHALL take s2 and dcnt SHALL clear.
REQ-017 Any glitch shorter than DEB_CYCLES synchronized cycles SHALL leave stable unchanged.
REQ-018 A press event SHALL be a 0->1 transition of stable. Release (1->0) SHALL generate no output.
REQ-019 S SHALL be 1 for exactly one cycle after a set press event if there is no rst press event in the same cycle. R is symmetric.
REQ-020 If both press events occur in the same cycle, S and R SHALL stay 0, and conflict SHALL be 1 for one cycle.
REQ-021 S and R SHALL never both be 1 in any cycle.
REQ-022 Latency: input held high from sampling edge k SHALL produce S (or R) high in the cycle after edge k+DEB_CYCLES+2, i.e. the (DEB_CYCLES+3)-th edge.
REQ-023 A held button SHALL produce exactly one pulse; a new pulse SHALL require a debounced release and a new press.
REQ-024 set_cnt SHALL increment in the same edge that registers S=1; rst_cnt likewise with R.
REQ-025 Counters SHALL wrap from 2^CNT_W-1 to 0 with no flag and SHALL NOT increment on conflict.

Reset
REQ-026 While reset=1, s1, s2, stable, dcnt, S, R, conflict, set_cnt and rst_cnt SHALL all be 0, immediately and without waiting for a clock edge.
REQ-027 A reset asserted mid-debounce SHALL discard the partial count. After release, a still-held button SHALL be treated as a new press with full latency.

Verification (DEB_CYCLES=4, CNT_W=8)
REQ-028 Hold btn_set high from edge 10 after reset release -> S=1 in the cycle after edge 16 only, set_cnt=1, R=0, conflict=0.
REQ-029 Pulse btn_rst high for 3 cycles, then low -> R stays 0, rst_cnt=0.
REQ-030 Raise btn_set and btn_rst on the same edge and hold -> S=R=0, conflict=1 for one cycle, both counters unchanged.
REQ-031 Perform 256 clean set press/release cycles -> set_cnt wraps to 0 and S pulses 256 times.
REQ-032 Assert reset for 2 cycles mid-debounce (3 cycles into a btn_set hold), keep btn_set high -> all outputs 0 during reset, then S pulses 7 edges after the first post-reset sampling edge.
REQ-033 Toggle btn_set every cycle for 20 cycles, then hold high -> exactly one S pulse, issued only after the hold.

Source files
------------

// File: rtl/sr_cmd_gen_if.sv
// Button-to-SR command bus: raw bouncing buttons in, registered command pulses and counters out.
// S, R and conflict are single-cycle pulses with no handshake: the consumer samples them every cycle.
interface sr_cmd_gen_if #(
    parameter int CNT_W = 8
);
    logic             btn_set;
    logic             btn_rst;
    logic             S;
    logic             R;
    logic             conflict;
    logic [CNT_W-1:0] set_cnt;
    logic [CNT_W-1:0] rst_cnt;

    modport master (
        output btn_set, btn_rst,
        input  S, R, conflict, set_cnt, rst_cnt
    );

    modport slave (
        input  btn_set, btn_rst,
        output S, R, conflict, set_cnt, rst_cnt
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// Synchronizes and debounces two buttons, turning each debounced press into a one-cycle
// S or R pulse for a downstream SR flip-flop; simultaneous presses raise conflict instead.
module sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    sr_cmd_gen_if.slave      bus
);
    localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES - 1);

    // Channel index 0 is the set button, index 1 the reset button.
    logic [1:0]       btn_raw;
    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic [1:0]       prev_q;
    logic [7:0]       dcnt_q [2];
    logic [7:0]       dcnt_d [2];
    logic [1:0]       press;
    logic             s_q;
    logic             s_d;
    logic             r_q;
    logic             r_d;
    logic             conf_q;
    logic             conf_d;
    logic [CNT_W-1:0] set_cnt_q;
    logic [CNT_W-1:0] set_cnt_d;
    logic [CNT_W-1:0] rst_cnt_q;
    logic [CNT_W-1:0] rst_cnt_d;

    assign btn_raw = {bus.btn_rst, bus.btn_set};

    always_comb begin
        stable_d  = stable_q;
        dcnt_d[0] = '0;
        dcnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == DEB_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A press is seen one edge after stable rises; releases never produce output.
    always_comb begin
        press     = stable_q & ~prev_q;
        s_d       = press[0] & ~press[1];
        r_d       = press[1] & ~press[0];
        conf_d    = press[0] & press[1];
        set_cnt_d = set_cnt_q + CNT_W'(s_d);
        rst_cnt_d = rst_cnt_q + CNT_W'(r_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            prev_q    <= '0;
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            conf_q    <= 1'b0;
            set_cnt_q <= '0;
            rst_cnt_q <= '0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            prev_q    <= stable_q;
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
            s_q       <= s_d;
            r_q       <= r_d;
            conf_q    <= conf_d;
            set_cnt_q <= set_cnt_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.conflict = conf_q;
    assign bus.set_cnt  = set_cnt_q;
    assign bus.rst_cnt  = rst_cnt_q;
endmodule
